fft_peak_search: RTL and testbench



---
 rtl/fft_peak_search.sv | 138 +++++++++++++
 tb/tb_fft_peak_search.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_search.sv
// Per-frame peak, second-peak and window sum over an FFT magnitude stream.
// Results and the result_valid/frame_err pulses land one cycle after the closing beat; no backpressure, one beat per cycle.
module fft_peak_search #(
    parameter int WIDTH       = 16,
    parameter int N           = 1024,
    parameter int IDX_W       = 10,
    parameter int DC_SKIP     = 2,
    parameter int SEARCH_HALF = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       amp,
    input  logic                   amp_sop,
    input  logic                   amp_valid,
    input  logic                   amp_eop,
    output logic [IDX_W-1:0]       peak_idx,
    output logic [WIDTH-1:0]       peak_amp,
    output logic [IDX_W-1:0]       sec_idx,
    output logic [WIDTH-1:0]       sec_amp,
    output logic [WIDTH+IDX_W-1:0] amp_sum,
    output logic                   result_valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int SUM_W = WIDTH + IDX_W;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [WIDTH-1:0]   w_max_amp, w_sec_amp;
    logic [IDX_W-1:0]   w_max_idx, w_sec_idx;
    logic [SUM_W-1:0]   w_sum;
    logic               pub_pend, err_pend;

    logic               start, in_win, last;
    logic [IDX_W-1:0]   k;
    logic [WIDTH-1:0]   b_max_amp, b_sec_amp, n_max_amp, n_sec_amp;
    logic [IDX_W-1:0]   b_max_idx, b_sec_idx, n_max_idx, n_sec_idx;
    logic [SUM_W-1:0]   b_sum, n_sum;

    assign start = amp_valid && amp_sop;
    assign k     = start ? '0 : cnt;
    assign last  = (k == IDX_W'(N - 1));
    // N is a power of two, so "below N/2" is just a clear index MSB.
    assign in_win = (k >= IDX_W'(DC_SKIP)) && ((SEARCH_HALF == 0) || !k[IDX_W-1]);

    always_comb begin
        b_max_amp = start ? '0 : w_max_amp;
        b_max_idx = start ? '0 : w_max_idx;
        b_sec_amp = start ? '0 : w_sec_amp;
        b_sec_idx = start ? '0 : w_sec_idx;
        b_sum     = start ? '0 : w_sum;
        n_max_amp = b_max_amp;
        n_max_idx = b_max_idx;
        n_sec_amp = b_sec_amp;
        n_sec_idx = b_sec_idx;
        n_sum     = b_sum;
        if (in_win) begin
            n_sum = b_sum + SUM_W'(amp);
            if (amp > b_max_amp) begin
                n_sec_amp = b_max_amp;
                n_sec_idx = b_max_idx;
                n_max_amp = amp;
                n_max_idx = k;
            end else if (amp > b_sec_amp) begin
                n_sec_amp = amp;
                n_sec_idx = k;
            end
        end
    end

    assign busy = (state == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            w_max_amp    <= '0;
            w_max_idx    <= '0;
            w_sec_amp    <= '0;
            w_sec_idx    <= '0;
            w_sum        <= '0;
            pub_pend     <= 1'b0;
            err_pend     <= 1'b0;
            peak_idx     <= '0;
            peak_amp     <= '0;
            sec_idx      <= '0;
            sec_amp      <= '0;
            amp_sum      <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            result_valid <= pub_pend;
            frame_err    <= err_pend;
            pub_pend     <= 1'b0;
            err_pend     <= 1'b0;
            // Working registers still hold the finished frame here even if a new sop clears them this edge.
            if (pub_pend) begin
                peak_idx <= w_max_idx;
                peak_amp <= w_max_amp;
                sec_idx  <= w_sec_idx;
                sec_amp  <= w_sec_amp;
                amp_sum  <= w_sum;
            end
            if (amp_valid && (start || state == COLLECT)) begin
                w_max_amp <= n_max_amp;
                w_max_idx <= n_max_idx;
                w_sec_amp <= n_sec_amp;
                w_sec_idx <= n_sec_idx;
                w_sum     <= n_sum;
                cnt       <= k + 1'b1;
                case (state)
                    IDLE: begin
                        if (amp_eop) err_pend <= 1'b1;
                        else         state    <= COLLECT;
                    end
                    COLLECT: begin
                        if (amp_sop) begin
                            err_pend <= 1'b1;
                            if (amp_eop) state <= IDLE;
                        end else if (amp_eop) begin
                            if (last) pub_pend <= 1'b1;
                            else      err_pend <= 1'b1;
                            state <= IDLE;
                        end else if (last) begin
                            err_pend <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_search.sv
// Randomized bench: two DUTs (half-band and full-band search) against a frame-level model.
module tb_fft_peak_search;

    localparam int WIDTH   = 16;
    localparam int N       = 1024;
    localparam int IDX_W   = 10;
    localparam int DC_SKIP = 2;
    localparam int SW      = WIDTH + IDX_W;
    localparam int BW      = 3 * IDX_W + 3 * WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] amp = '0;
    logic             amp_sop = 1'b0, amp_valid = 1'b0, amp_eop = 1'b0;

    logic [IDX_W-1:0] pk_i [2];
    logic [WIDTH-1:0] pk_a [2];
    logic [IDX_W-1:0] sc_i [2];
    logic [WIDTH-1:0] sc_a [2];
    logic [SW-1:0]    sm   [2];
    logic             rv   [2];
    logic             fe   [2];
    logic             bz   [2];

    always #5 clk = ~clk;

    fft_peak_search #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W), .DC_SKIP(DC_SKIP), .SEARCH_HALF(1)) u_half (
        .clk(clk), .rst_n(rst_n), .amp(amp), .amp_sop(amp_sop), .amp_valid(amp_valid), .amp_eop(amp_eop),
        .peak_idx(pk_i[0]), .peak_amp(pk_a[0]), .sec_idx(sc_i[0]), .sec_amp(sc_a[0]), .amp_sum(sm[0]),
        .result_valid(rv[0]), .frame_err(fe[0]), .busy(bz[0]));

    fft_peak_search #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W), .DC_SKIP(DC_SKIP), .SEARCH_HALF(0)) u_full (
        .clk(clk), .rst_n(rst_n), .amp(amp), .amp_sop(amp_sop), .amp_valid(amp_valid), .amp_eop(amp_eop),
        .peak_idx(pk_i[1]), .peak_amp(pk_a[1]), .sec_idx(sc_i[1]), .sec_amp(sc_a[1]), .amp_sum(sm[1]),
        .result_valid(rv[1]), .frame_err(fe[1]), .busy(bz[1]));

    int total = 0;
    int passed = 0;

    // Model state: expected outputs after the next edge, plus the event from the previous beat.
    int unsigned fq[$];
    bit          in_frame = 0;
    bit          pend_good = 0, pend_err = 0;
    int unsigned p_pi[2], p_pa[2], p_si[2], p_sa[2], p_sum[2];
    int unsigned e_pi[2], e_pa[2], e_si[2], e_sa[2], e_sum[2];
    bit          e_rv = 0, e_fe = 0, e_busy = 0;
    int unsigned fr[N+1];

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic void eval(input bit half, output int unsigned pi, output int unsigned pa,
                                 output int unsigned si, output int unsigned sa, output int unsigned s);
        int hi;
        hi = half ? N / 2 : N;
        pi = 0; pa = 0; si = 0; sa = 0; s = 0;
        for (int j = DC_SKIP; j < hi; j++) begin
            s += fq[j];
            if (fq[j] > pa) begin pa = fq[j]; pi = j; end
        end
        for (int j = DC_SKIP; j < hi; j++)
            if (j != int'(pi) && fq[j] > sa) begin sa = fq[j]; si = j; end
    endfunction

    task automatic model_reset();
        fq.delete();
        in_frame = 0; pend_good = 0; pend_err = 0;
        e_rv = 0; e_fe = 0; e_busy = 0;
        for (int d = 0; d < 2; d++) begin
            e_pi[d] = 0; e_pa[d] = 0; e_si[d] = 0; e_sa[d] = 0; e_sum[d] = 0;
        end
    endtask

    task automatic model_advance(input bit v, input bit s, input bit e, input logic [WIDTH-1:0] a);
        e_rv = pend_good;
        e_fe = pend_err;
        if (pend_good)
            for (int d = 0; d < 2; d++) begin
                e_pi[d] = p_pi[d]; e_pa[d] = p_pa[d]; e_si[d] = p_si[d]; e_sa[d] = p_sa[d]; e_sum[d] = p_sum[d];
            end
        pend_good = 0;
        pend_err  = 0;
        if (v) begin
            if (s) begin
                pend_err = e || in_frame;
                fq.delete();
                fq.push_back(a);
                in_frame = !e;
            end else if (in_frame) begin
                fq.push_back(a);
                if (e) begin
                    if (fq.size() == N) begin
                        pend_good = 1;
                        eval(1, p_pi[0], p_pa[0], p_si[0], p_sa[0], p_sum[0]);
                        eval(0, p_pi[1], p_pa[1], p_si[1], p_sa[1], p_sum[1]);
                    end else pend_err = 1;
                    in_frame = 0;
                end else if (fq.size() == N) begin
                    pend_err = 1;
                    in_frame = 0;
                end
            end
        end
        e_busy = in_frame;
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++)
            chk(d == 0 ? "cycle_half" : "cycle_full",
                {pk_i[d], pk_a[d], sc_i[d], sc_a[d], sm[d], rv[d], fe[d], bz[d]},
                {IDX_W'(e_pi[d]), WIDTH'(e_pa[d]), IDX_W'(e_si[d]), WIDTH'(e_sa[d]), SW'(e_sum[d]),
                 e_rv, e_fe, e_busy});
    endtask

    task automatic step(input bit v, input bit s, input bit e, input logic [WIDTH-1:0] a);
        @(negedge clk);
        compare();
        amp_valid = v; amp_sop = s; amp_eop = e; amp = a;
        model_advance(v, s, e, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0);
    endtask

    task automatic send_frame(input int len, input bit with_eop, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++)
                step(0, 1'($urandom_range(1)), 1'($urandom_range(1)), WIDTH'($urandom));
            step(1, i == 0, with_eop && i == len - 1, WIDTH'(fr[i]));
        end
    endtask

    task automatic fill(input int unsigned v);
        for (int i = 0; i <= N; i++) fr[i] = v;
    endtask

    task automatic pin(input string nm, input int d, input int unsigned pi, input int unsigned pa,
                       input int unsigned si, input int unsigned sa, input int unsigned s);
        chk({nm, "_peak_idx"}, pk_i[d], pi);
        chk({nm, "_peak_amp"}, pk_a[d], pa);
        chk({nm, "_sec_idx"},  sc_i[d], si);
        chk({nm, "_sec_amp"},  sc_a[d], sa);
        chk({nm, "_sum"},      sm[d],   s);
        chk({nm, "_model_peak"}, e_pi[d], pi);
        chk({nm, "_model_sum"},  e_sum[d], s);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        idle(3);
        #1 rst_n = 1'b1;
        idle(2);

        fill(10); fr[100] = 5000; fr[300] = 3000;
        send_frame(N, 1, 0); idle(3);
        pin("tone_half", 0, 100, 5000, 300, 3000, 13080);
        pin("tone_full", 1, 100, 5000, 300, 3000, 18200);

        fill(0); fr[1] = 60000; fr[600] = 50000; fr[511] = 40000;
        send_frame(N, 1, 0); idle(3);
        pin("edge_half", 0, 511, 40000, 0, 0, 40000);
        pin("edge_full", 1, 600, 50000, 511, 40000, 90000);

        fill(0); fr[50] = 7000; fr[70] = 7000;
        send_frame(N, 1, 50); idle(3);
        pin("tie_gap", 0, 50, 7000, 70, 7000, 14000);
        send_frame(N, 1, 0); idle(3);
        pin("tie_nogap", 1, 50, 7000, 70, 7000, 14000);

        fill(99);
        send_frame(501, 1, 0); idle(3);
        pin("short_kept", 0, 50, 7000, 70, 7000, 14000);

        fill(5); fr[123] = 900;
        send_frame(200, 0, 0);
        send_frame(N, 1, 10); idle(3);

        send_frame(N + 1, 0, 0); idle(3);
        step(1, 1, 1, 16'd777); idle(3);

        fill(1); fr[10] = 4000;
        send_frame(N, 1, 0);
        fill(1); fr[20] = 4000;
        send_frame(N, 1, 0); idle(3);
        pin("b2b_second", 0, 20, 4000, 2, 1, 510 + 3999);

        for (int f = 0; f < 6; f++) begin
            int unsigned r;
            r = (f % 2 == 0) ? 65535 : 7;
            for (int i = 0; i <= N; i++) fr[i] = $urandom_range(r);
            send_frame(N, 1, 30);
            idle($urandom_range(2));
        end

        fill(3); fr[77] = 1234;
        send_frame(401, 0, 0);
        @(negedge clk);
        compare();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk(d == 0 ? "async_reset_half" : "async_reset_full",
                {pk_i[d], pk_a[d], sc_i[d], sc_a[d], sm[d], rv[d], fe[d], bz[d]}, '0);
        model_reset();
        amp_valid = 1'b0;
        idle(2);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 0, i == 5, WIDTH'($urandom));
        idle(2);
        fill(2); fr[333] = 2222;
        send_frame(N, 1, 0); idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
